sync_ram: RTL and testbench
===========================

SYNC_RAM -- requirements
Module: sync_ram

Interface
REQ-001 The module SHALL have the parameter DATA_W, default 32, meaning data word width in bits (multiple of 8).
REQ-002 The module SHALL have the parameter ADDR_W, default 10, meaning word-address width.
REQ-003 The module SHALL have the parameter DEPTH, default 1024, meaning number of implemented words (≤ 2^ADDR_W).
REQ-004 The module SHALL have the parameter WAIT_STATES, default 1, meaning extra cycles per access (0..15).
REQ-005 The module SHALL have the port clk, input, 1 bit, meaning the single clock; all logic is on the rising edge.
REQ-006 The module SHALL have the port rst_n, input, 1 bit, meaning reset; it is asynchronous and active-low.
REQ-007 The module SHALL have the port req, input, 1 bit, meaning access request.
REQ-008 The module SHALL have the port we, input, 1 bit, meaning 1 = write and 0 = read.
REQ-009 The module SHALL have the port addr, input, ADDR_W bits, meaning word address.
REQ-010 The module SHALL have the port be, input, DATA_W/8 bits, meaning byte enables for writes.
REQ-011 The module SHALL have the port wdata, input, DATA_W bits, meaning write data.
REQ-012 The module SHALL have the port rdata, output, DATA_W bits, meaning read data.
REQ-013 The module SHALL have the port ready, output, 1 bit, meaning a one-cycle access-complete pulse.
REQ-014 The module SHALL have the port err, output, 1 bit, meaning address out of range; valid with ready.
REQ-015 The module SHALL have the port perr, output, 1 bit, meaning read parity error; valid with ready.

Function
REQ-016 The block SHALL use separate unidirectional read and write buses; no tristate bus.
REQ-017 The state machine SHALL have the states IDLE, WAIT and DONE.
REQ-018 In IDLE, req=1 SHALL capture we/addr/be/wdata into internal registers, load the wait counter with WAIT_STATES, and move to WAIT (or to DONE if WAIT_STATES=0).
REQ-019 In WAIT, the counter SHALL decrement each cycle; at count 1 the FSM SHALL move to DONE.
REQ-020 In DONE, the captured access SHALL execute, ready SHALL be asserted for exactly that cycle, and the FSM SHALL return to IDLE.
REQ-021 Latency SHALL be WAIT_STATES+1 cycles from the accepting edge to the ready cycle.
REQ-022 req SHALL be ignored in WAIT and DONE; a new request is accepted no earlier than the cycle after ready.
REQ-023 Back-to-back throughput SHALL be one access per WAIT_STATES+2 cycles.
REQ-024 A write SHALL update only the bytes whose be bit is 1; be=0 SHALL be a legal no-op write that still pulses ready.
REQ-025 A read SHALL load rdata with the stored word in the ready cycle; rdata SHALL hold until the next read completes, and writes SHALL not alter rdata.
REQ-026 For a captured addr ≥ DEPTH: err=1 with ready; a write SHALL not modify memory; a read SHALL leave rdata unchanged.
REQ-027 err and perr SHALL be 0 whenever ready=0.
REQ-028 Inputs changing after acceptance SHALL have no effect on the access in flight.

Reset
REQ-029 When rst_n=0, the FSM SHALL go to IDLE and ready, err, perr, rdata and the counter SHALL be 0, asynchronously.
REQ-030 A reset asserted mid-access SHALL abort the access with no memory write and no ready pulse.
REQ-031 Memory array contents SHALL not be reset; reads of never-written words SHALL return unspecified data.
REQ-032 The FSM SHALL accept a request on the first rising edge after rst_n deasserts.

Configuration
REQ-033 With RAM_PARITY_EN defined, the block SHALL store one even-parity bit per byte, update the parity bit of each enabled byte on writes, and check all bytes on reads.
REQ-034 With RAM_PARITY_EN defined, a read SHALL set perr=1 in the ready cycle on any byte mismatch, with rdata still returning the stored data.
REQ-035 With RAM_PARITY_EN undefined, no parity storage SHALL exist and perr SHALL be tied to 0.

Verification
REQ-036 The bench SHALL cover: WAIT_STATES=1; write addr 0..15 with 12345678+i, be=4'hF, then read 0..15 -> rdata=12345678+i, ready exactly 2 cycles after each accept.
REQ-037 The bench SHALL cover: write 32'h11223344 to addr 5, then write be=4'b0101 wdata 32'hAABBCCDD, read addr 5 -> 32'h11BB33DD.
REQ-038 The bench SHALL cover: DEPTH=1000, write addr 1000, then read addr 1000 -> err=1 both times, rdata unchanged from the previous read, no memory word changed.
REQ-039 The bench SHALL cover: WAIT_STATES=3, req held high continuously -> ready every 5th cycle, and a req pulse during WAIT ignored.
REQ-040 The bench SHALL cover: rst_n low in the WAIT of a write to addr 7 (old value 32'h0) -> no ready, addr 7 reads 32'h0 after reset, and rdata=0 immediately on reset.
REQ-041 The bench SHALL cover: with RAM_PARITY_EN, write addr 3, force-flip stored parity of byte 0, read addr 3 -> perr=1 with ready; without RAM_PARITY_EN -> perr=0 always.

Source files
------------

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with a fixed-latency request/ready handshake and byte enables.
// Optional per-byte even parity storage and read checking when RAM_PARITY_EN is defined.
module sync_ram #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                err,
    output logic                perr
);

    localparam int NB = DATA_W / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t state, state_nxt;
    logic [3:0] cnt;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NB-1:0]     be_q;
    logic [DATA_W-1:0] wdata_q;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [NB-1:0]     acc_be;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_oor;
    logic [IW-1:0]     idx;
    logic              exec;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = (WS == 4'd0) ? DONE : WAIT;
            WAIT: if (cnt == 4'd1) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The access executes on the edge entering DONE so rdata is valid alongside ready.
    // With zero wait states that edge is also the capture edge, hence the live-input bypass.
    always_comb begin
        ready     = (state == DONE);
        err       = ready && ({1'b0, addr_q} >= DEPTH_X);
        exec      = rst_n && (state != DONE) && (state_nxt == DONE);
        acc_we    = (state == IDLE) ? we    : we_q;
        acc_addr  = (state == IDLE) ? addr  : addr_q;
        acc_be    = (state == IDLE) ? be    : be_q;
        acc_wdata = (state == IDLE) ? wdata : wdata_q;
        acc_oor   = ({1'b0, acc_addr} >= DEPTH_X);
        idx       = acc_addr[IW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && req) begin
            cnt     <= WS;
            we_q    <= we;
            addr_q  <= addr;
            be_q    <= be;
            wdata_q <= wdata;
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (exec && acc_we && !acc_oor) begin
            for (int b = 0; b < NB; b++) begin
                if (acc_be[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            rdata <= '0;
        else if (exec && !acc_we && !acc_oor)  rdata <= mem[idx];
    end

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic          par_bad;
    logic          perr_q;

    always_ff @(posedge clk) begin
        if (exec && acc_we && !acc_oor) begin
            for (int b = 0; b < NB; b++) begin
                if (acc_be[b]) par_mem[idx][b] <= ^acc_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        par_bad = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if ((^mem[idx][8*b +: 8]) != par_mem[idx][b]) par_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    perr_q <= 1'b0;
        else if (exec) perr_q <= !acc_we && !acc_oor && par_bad;
    end

    assign perr = ready && perr_q;
`else
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_sync_ram.sv
// Randomized bench for sync_ram: two instances (1 and 3 wait states, DEPTH=1000) checked
// each cycle against a schedule/array model, plus literal directed cases.
module tb_sync_ram;

    localparam int DEPTH = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       req, we, ready, err, perr;
    logic [1:0][9:0]  addr;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] wdata, rdata;

    int n_chk = 0;
    int n_fail = 0;

    function automatic int wsf(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_ram
        sync_ram #(.DATA_W(32), .ADDR_W(10), .DEPTH(DEPTH), .WAIT_STATES(g == 0 ? 1 : 3)) dut (
            .clk(clk), .rst_n(rst_n), .req(req[g]), .we(we[g]), .addr(addr[g]), .be(be[g]),
            .wdata(wdata[g]), .rdata(rdata[g]), .ready(ready[g]), .err(err[g]), .perr(perr[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a memory array plus a completion schedule per instance.
    bit [31:0]   mm [2][1024];
    bit [3:0]    mk [2][1024];
    bit          corrupt [2][1024];
    int          cyc = 0;
    bit          pend [2];
    int          due [2], free_at [2], rdy_cyc [2];
    bit          p_we [2];
    int          p_a [2];
    logic [3:0]  p_be [2];
    logic [31:0] p_d [2];
    logic [31:0] e_rd [2], e_rm [2];
    bit          e_err [2], e_perr [2];

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                pend[g] = 0; free_at[g] = 0; rdy_cyc[g] = -1;
                e_rd[g] = '0; e_rm[g] = '1; e_err[g] = 0; e_perr[g] = 0;
            end else if (!pend[g] && cyc >= free_at[g] && req[g] === 1'b1) begin
                pend[g] = 1; p_we[g] = we[g]; p_a[g] = int'(addr[g]);
                p_be[g] = be[g]; p_d[g] = wdata[g];
                due[g] = cyc + wsf(g) + 1;
            end
        end
        cyc++;
        for (int g = 0; g < 2; g++) begin
            if (rst_n && pend[g] && cyc == due[g]) begin
                pend[g] = 0; free_at[g] = due[g] + 1; rdy_cyc[g] = due[g];
                e_err[g] = (p_a[g] >= DEPTH); e_perr[g] = 0;
                if (!e_err[g] && p_we[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (p_be[g][b]) begin
                            mm[g][p_a[g]][8*b +: 8] = p_d[g][8*b +: 8];
                            mk[g][p_a[g]][b] = 1'b1;
                        end
                end else if (!e_err[g]) begin
                    e_rd[g] = mm[g][p_a[g]];
                    for (int b = 0; b < 4; b++) e_rm[g][8*b +: 8] = {8{mk[g][p_a[g]][b]}};
                    e_perr[g] = corrupt[g][p_a[g]];
                end
            end
        end
    end

    always @(negedge clk) begin
        logic r;
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                chk("rst_ready", ready[g], 0); chk("rst_err", err[g], 0);
                chk("rst_perr", perr[g], 0);   chk("rst_rdata", rdata[g], 0);
            end else begin
                r = (cyc == rdy_cyc[g]);
                chk("ready", ready[g], r);
                chk("err", err[g], r && e_err[g]);
                chk("perr", perr[g], r && e_perr[g]);
                chk("rdata", rdata[g] & e_rm[g], e_rd[g] & e_rm[g]);
            end
        end
    end

    // Call just after a negedge with the instance idle; returns one negedge after ready.
    task automatic acc(input int g, input bit w, input int a, input logic [3:0] b,
                       input logic [31:0] d, input bit junk, output logic [31:0] rd,
                       output logic e, output logic pe, output int lat);
        req[g] = 1'b1; we[g] = w; addr[g] = a[9:0]; be[g] = b; wdata[g] = d;
        lat = 0; rd = '0; e = 1'b0; pe = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ready[g]) begin
                lat = n; rd = rdata[g]; e = err[g]; pe = perr[g]; req[g] = 1'b0;
                break;
            end
            if (junk) begin
                req[g] = 1'($urandom); we[g] = 1'($urandom); addr[g] = 10'($urandom);
                be[g] = 4'($urandom); wdata[g] = $urandom;
            end else begin
                req[g] = 1'b0;
            end
        end
        if (lat == 0) begin
            n_chk++; n_fail++;
            $display("FAIL timeout: no ready on instance %0d within 40 cycles", g);
        end
        req[g] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic e, pe;
        int lat, cnt_r, last, a;
        rst_n = 1'b0; req = '0; we = '0; addr = '0; be = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Fill and read back 16 words; accept is on the first edge after reset release.
        for (int i = 0; i < 16; i++) begin
            acc(0, 1, i, 4'hF, 32'h12345678 + i, 0, rd, e, pe, lat);
            chk("wr_lat", lat, 2);
        end
        for (int i = 0; i < 16; i++) begin
            acc(0, 0, i, 4'hF, 32'h0, 0, rd, e, pe, lat);
            chk("rd_lat", lat, 2);
            chk("rd_data", rd, 32'h12345678 + i);
        end

        acc(0, 1, 5, 4'hF, 32'h11223344, 0, rd, e, pe, lat);
        acc(0, 1, 5, 4'b0101, 32'hAABBCCDD, 0, rd, e, pe, lat);
        acc(0, 0, 5, 4'hF, 32'h0, 0, rd, e, pe, lat);
        chk("be_merge", rd, 32'h11BB33DD);

        acc(0, 1, 1000, 4'hF, 32'hCAFEF00D, 0, rd, e, pe, lat);
        chk("oor_wr_err", e, 1);
        acc(0, 0, 1000, 4'hF, 32'h0, 0, rd, e, pe, lat);
        chk("oor_rd_err", e, 1);
        chk("oor_rd_hold", rd, 32'h11BB33DD);
        acc(0, 0, 15, 4'hF, 32'h0, 0, rd, e, pe, lat);
        chk("oor_no_alias", rd, 32'h12345678 + 15);

        // Reset during the WAIT of a write to addr 7.
        acc(0, 1, 7, 4'hF, 32'h0, 0, rd, e, pe, lat);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 10'd7; be[0] = 4'hF; wdata[0] = 32'hDEADBEEF;
        @(negedge clk);
        req[0] = 1'b0;
        chk("wait_no_ready", ready[0], 0);
        #2 rst_n = 1'b0;
        #1 chk("rst_rdata_now", rdata[0], 0);
        chk("rst_ready_now", ready[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc(0, 0, 7, 4'hF, 32'h0, 0, rd, e, pe, lat);
        chk("rst_first_lat", lat, 2);
        chk("rst_aborted_wr", rd, 32'h0);

        // Held request on the 3-wait-state instance.
        cnt_r = 0; last = -1;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'd2; be[1] = 4'hF;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (ready[1]) begin
                cnt_r++;
                if (last >= 0) chk("held_gap", n - last, 5);
                last = n;
            end
        end
        req[1] = 1'b0;
        chk("held_count", cnt_r, 6);
        @(negedge clk);
        cnt_r = 0;
        req[1] = 1'b1;
        @(negedge clk); req[1] = 1'b0;
        @(negedge clk); req[1] = 1'b1;
        @(negedge clk); req[1] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ready[1]) cnt_r++;
        end
        chk("wait_pulse_ignored", cnt_r, 1);

        // Randomized traffic with input churn while busy.
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < 150; k++) begin
                a = (k % 5 == 0) ? $urandom_range(0, 1023) : (k % 5 == 1) ? $urandom_range(995, 1005)
                                 : $urandom_range(0, 40);
                acc(g, 1'($urandom), a, 4'($urandom), $urandom, 1, rd, e, pe, lat);
                chk("rand_lat", lat, wsf(g) + 1);
                chk("rand_err", e, (a >= DEPTH));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

`ifdef RAM_PARITY_EN
        acc(0, 1, 3, 4'hF, 32'h0F0F0F01, 0, rd, e, pe, lat);
        g_ram[0].dut.par_mem[3][0] = ~g_ram[0].dut.par_mem[3][0];
        corrupt[0][3] = 1'b1;
        acc(0, 0, 3, 4'hF, 32'h0, 0, rd, e, pe, lat);
        chk("parity_perr", pe, 1);
        chk("parity_data", rd, 32'h0F0F0F01);
`else
        acc(0, 1, 3, 4'hF, 32'h0F0F0F01, 0, rd, e, pe, lat);
        acc(0, 0, 3, 4'hF, 32'h0, 0, rd, e, pe, lat);
        chk("no_parity_perr", pe, 0);
        chk("no_parity_data", rd, 32'h0F0F0F01);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
